pwm_preconditioner: RTL
=======================

# pwm_preconditioner

Streaming producer of per-transducer PWM edge times. Converts each (DUTY, PHASE, CYCLE) sample into a wrapped RISE/FALL pair in the time-counter domain and writes it, with a transducer address, into the per-channel edge buffers. Those buffers latch RISE/FALL into the PWM generators at each channel's cycle boundary. Sits between the modulation/STM datapath and the edge buffer array.

## Interface
- WIDTH, 13: bit width of DUTY, PHASE, CYCLE, RISE, FALL.
- DEPTH, 249: transducers per frame; ADDR counts 0..DEPTH-1.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; aborts any in-flight frame and restarts addressing at 0.
- IN_VALID  in  1  sample strobe; one sample accepted per asserted cycle, no backpressure.
- DUTY  in  WIDTH  requested on-time in counts.
- PHASE  in  WIDTH  centre of the on-pulse in counts; upstream guarantees PHASE < 2*CYCLE.
- CYCLE  in  WIDTH  PWM period in counts; upstream guarantees CYCLE >= 2.
- OUT_VALID  out  1  RISE/FALL/ADDR valid this cycle.
- ADDR  out  $clog2(DEPTH)  transducer index of the output sample.
- RISE  out  WIDTH  time count at which the output goes high.
- FALL  out  WIDTH  time count at which the output goes low.
- DONE  out  1  one-cycle pulse coincident with the output at ADDR = DEPTH-1.

## Operation
- Fixed 3-stage pipeline. There are no stalls and no FSM beyond the valid shift register and the address counter.
- Stage 1 registers the sample and applies two corrections:
  - d = min(DUTY, CYCLE).
  - p = PHASE - CYCLE if PHASE >= CYCLE, else PHASE.
  - Stage 1 also computes h = d >> 1 (floor) and g = d - h.
- Stage 2, internal width WIDTH+1 (no overflow):
  - rr = p - h, computed as p + CYCLE - h when p < h.
  - ff = p + g.
- Stage 3:
  - RISE = rr.
  - FALL = ff - CYCLE if ff >= CYCLE, else ff.
- Special cases, applied in stage 3 and overriding the above:
  - d == 0 gives RISE = 0, FALL = 0 (always low).
  - d == CYCLE gives RISE = 0, FALL = CYCLE (always high).
- Address counter:
  - Increments on every OUT_VALID.
  - Wraps from DEPTH-1 to 0.
  - DONE = OUT_VALID && ADDR == DEPTH-1.
- START:
  - Clears all pipeline valids and the address counter on the next edge.
  - Partial frames are discarded and produce no DONE.
- START and IN_VALID in the same cycle: the flush happens and that sample is accepted as ADDR 0.
- Reset mid-frame: identical to START, asynchronous.
- More than DEPTH samples between STARTs: addressing wraps and a new frame begins. Each completed frame pulses DONE.

## Timing
- Reset values: OUT_VALID = 0, DONE = 0, ADDR = 0, RISE = 0, FALL = 0. Pipeline valids are all 0.
- Latency: a sample with IN_VALID at edge n appears with OUT_VALID high after edge n+3.
- Throughput: one sample per cycle sustained. Back-to-back samples give back-to-back outputs.
- RISE/FALL/ADDR hold their last values while OUT_VALID = 0. Only OUT_VALID and DONE are pulses.
- START at edge n: OUT_VALID = 0 for cycles n+1..n+3 unless refilled by new input.

## Test plan
- Basic centring: CYCLE=4096, DUTY=2048, PHASE=1024 -> RISE=0, FALL=2048, ADDR=0, OUT_VALID 3 cycles after IN_VALID.
- Rise wrap: CYCLE=4096, DUTY=2048, PHASE=0 -> RISE=3072, FALL=1024. Then CYCLE=100, DUTY=5, PHASE=10 -> RISE=8, FALL=13 (odd duty, floor half on rise side).
- Phase reduction and fall wrap: CYCLE=4096, DUTY=10, PHASE=4100 -> RISE=4095, FALL=9. Then CYCLE=100, DUTY=20, PHASE=95 -> RISE=85, FALL=5.
- Extremes: DUTY=0 -> RISE=0, FALL=0. DUTY=5000 with CYCLE=4096 -> RISE=0, FALL=4096. DUTY=4096 -> same.
- Full frame: 249 back-to-back samples -> ADDR 0..248 contiguous. DONE high exactly with ADDR=248. The 250th sample -> ADDR=0.
- Abort:
  - 100 samples, then START together with IN_VALID -> in-flight outputs suppressed, that sample emerges at ADDR=0, no DONE for the aborted frame.
  - RST_N asserted mid-frame -> all outputs reset immediately (asynchronous).

Source files
------------

// File: rtl/pwm_preconditioner.sv
// Streaming preconditioner: turns (DUTY, PHASE, CYCLE) samples into wrapped
// RISE/FALL edge pairs plus a transducer address for the per-channel edge buffers.
module pwm_preconditioner #(
  parameter  int unsigned WIDTH = 13,
  parameter  int unsigned DEPTH = 249,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] DUTY,
  input  logic [WIDTH-1:0] PHASE,
  input  logic [WIDTH-1:0] CYCLE,
  output logic             OUT_VALID,
  output logic [AW-1:0]    ADDR,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             DONE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Stage 1: clamped duty, reduced phase, split halves
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] h1_q, h1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] c1_q, c1_d;

  // Stage 2: unwrapped edges and special-case flags
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] rr2_q, rr2_d;
  logic [WIDTH:0]   ff2_q, ff2_d;
  logic [WIDTH-1:0] c2_q, c2_d;
  logic             zero2_q, zero2_d;
  logic             full2_q, full2_d;

  // Stage 3: registered outputs and frame address counter
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             done_q, done_d;
  logic [AW-1:0]    addr_cnt_q, addr_cnt_d;

  logic [WIDTH-1:0] duty_sat;
  logic [WIDTH-1:0] phase_red;
  logic [WIDTH-1:0] half_lo;
  logic [WIDTH:0]   ff_sub;
  logic [WIDTH-1:0] fall_wrap;

  always_comb begin
    duty_sat  = (DUTY > CYCLE) ? CYCLE : DUTY;
    phase_red = (PHASE >= CYCLE) ? PHASE - CYCLE : PHASE;
    half_lo   = duty_sat >> 1;

    // A START flushes in-flight samples but still admits the coincident input
    v1_d = IN_VALID;
    d1_d = IN_VALID ? duty_sat           : d1_q;
    h1_d = IN_VALID ? half_lo            : h1_q;
    g1_d = IN_VALID ? duty_sat - half_lo : g1_q;
    p1_d = IN_VALID ? phase_red          : p1_q;
    c1_d = IN_VALID ? CYCLE              : c1_q;
  end

  always_comb begin
    v2_d    = v1_q && !START;
    rr2_d   = rr2_q;
    ff2_d   = ff2_q;
    c2_d    = c2_q;
    zero2_d = zero2_q;
    full2_d = full2_q;
    if (v1_q) begin
      // p - h wrapped into [0, CYCLE); h - p < CYCLE so WIDTH bits suffice
      rr2_d   = (p1_q < h1_q) ? c1_q - (h1_q - p1_q) : p1_q - h1_q;
      ff2_d   = {1'b0, p1_q} + {1'b0, g1_q};
      c2_d    = c1_q;
      zero2_d = (d1_q == '0);
      full2_d = (d1_q == c1_q);
    end
  end

  always_comb begin
    // ff < 2*CYCLE, so the borrow of ff - CYCLE alone selects the wrap
    ff_sub    = ff2_q - {1'b0, c2_q};
    fall_wrap = ff_sub[WIDTH] ? ff2_q[WIDTH-1:0] : ff_sub[WIDTH-1:0];

    out_valid_d = v2_q && !START;
    rise_d      = rise_q;
    fall_d      = fall_q;
    addr_d      = addr_q;
    done_d      = out_valid_d && (addr_cnt_q == LAST_ADDR);
    if (out_valid_d) begin
      addr_d = addr_cnt_q;
      if (zero2_q) begin
        rise_d = '0;
        fall_d = '0;
      end else if (full2_q) begin
        rise_d = '0;
        fall_d = c2_q;
      end else begin
        rise_d = rr2_q;
        fall_d = fall_wrap;
      end
    end

    addr_cnt_d = addr_cnt_q;
    if (START) begin
      addr_cnt_d = '0;
    end else if (v2_q) begin
      addr_cnt_d = (addr_cnt_q == LAST_ADDR) ? '0 : addr_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q        <= 1'b0;
      d1_q        <= '0;
      h1_q        <= '0;
      g1_q        <= '0;
      p1_q        <= '0;
      c1_q        <= '0;
      v2_q        <= 1'b0;
      rr2_q       <= '0;
      ff2_q       <= '0;
      c2_q        <= '0;
      zero2_q     <= 1'b0;
      full2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      done_q      <= 1'b0;
      addr_cnt_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      d1_q        <= d1_d;
      h1_q        <= h1_d;
      g1_q        <= g1_d;
      p1_q        <= p1_d;
      c1_q        <= c1_d;
      v2_q        <= v2_d;
      rr2_q       <= rr2_d;
      ff2_q       <= ff2_d;
      c2_q        <= c2_d;
      zero2_q     <= zero2_d;
      full2_q     <= full2_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      done_q      <= done_d;
      addr_cnt_q  <= addr_cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ADDR      = addr_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign DONE      = done_q;

endmodule
